// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave timing core.
// Mode encoding, FSM states and strobe-edge selection.
package spi_pkg;

  typedef logic [1:0] spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = 2'b00;
  localparam spi_mode_t SPI_MODE1 = 2'b01;
  localparam spi_mode_t SPI_MODE2 = 2'b10;
  localparam spi_mode_t SPI_MODE3 = 2'b11;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  function automatic logic sample_on_rise(input spi_mode_t m);
    return ~(m[1] ^ m[0]);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-flop bit synchronizer for asynchronous SPI pins.
// Synchronous active-high reset clears every stage.
module spi_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= {sr[N-2:0], d};
  end

  assign q = sr[N-1];

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave timing core: synchronizes CS/SCLK and emits
// one-clock shift/sample strobes according to the SPI mode.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       cs,
  input  logic       sclk,
  output logic       shift,
  output logic       sample
);

  logic      cs_s, sclk_s;
  logic      sclk_d, cs_q;
  logic      rise_q, fall_q;
  state_t    state_q, state_n;
  spi_mode_t mode_q, mode_n;
  logic      shift_n, sample_n;

  spi_sync #(.N(SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d     (cs),
    .q     (cs_s)
  );

  spi_sync #(.N(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sclk),
    .q     (sclk_s)
  );

  // cs_q trails cs_s by one clk so an edge arriving with CS
  // assertion is still seen in IDLE and dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_d  <= 1'b0;
      cs_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      state_q <= IDLE;
      mode_q  <= SPI_MODE0;
      shift   <= 1'b0;
      sample  <= 1'b0;
    end else begin
      sclk_d  <= sclk_s;
      cs_q    <= cs_s;
      rise_q  <= sclk_s & ~sclk_d;
      fall_q  <= ~sclk_s & sclk_d;
      state_q <= state_n;
      mode_q  <= mode_n;
      shift   <= shift_n;
      sample  <= sample_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    mode_n   = mode_q;
    shift_n  = 1'b0;
    sample_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_q) begin
          state_n = ACTIVE;
          mode_n  = mode;
        end
      end
      ACTIVE: begin
        if (cs_q) begin
          state_n = IDLE;
        end else if (sample_on_rise(mode_q)) begin
          sample_n = rise_q;
          shift_n  = fall_q;
        end else begin
          shift_n  = rise_q;
          sample_n = fall_q;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm with an event-level
// model: each qualified SCLK edge predicts one strobe.
module tb_spi_slave_fsm;

  localparam int LAT = 3;

  typedef struct {
    int c;
    bit smp;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic       shift, sample;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cs_fall = 0;
  logic [1:0] mode_lat = 2'b00;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  spi_slave_fsm #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .cs     (cs),
    .sclk   (sclk),
    .shift  (shift),
    .sample (sample)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // mode 0/3 capture on the rising edge, mode 1/2 on the falling one
  function automatic bit model_sample(input logic [1:0] m, input bit rising);
    case (m)
      2'b00, 2'b11: return rising;
      default:      return !rising;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (shift === 1'b1 && sample === 1'b1) check("exclusive", 1, 0);
    if (sample === 1'b1) obs_q.push_back('{cyc, 1'b1});
    if (shift === 1'b1) obs_q.push_back('{cyc, 1'b0});
  end

  // Called at a negedge; the edge is captured at posedge cyc+1.
  task automatic toggle();
    bit rising;
    rising = (sclk == 1'b0);
    if (!cs && cs_fall < cyc + 1)
      exp_q.push_back('{cyc + 1 + LAT, model_sample(mode_lat, rising)});
    sclk = ~sclk;
  endtask

  task automatic compare(input string tag);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_missing"}, 0, 1);
      end else begin
        o = obs_q.pop_front();
        check({tag, "_cyc"}, o.c, e.c);
        check({tag, "_kind"}, int'(o.smp), int'(e.smp));
      end
    end
    check({tag, "_extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  task automatic xfer(input string tag, input logic [1:0] m,
                      input logic lvl, input int edges,
                      input bit coincide, input bit flip);
    @(negedge clk);
    sclk = lvl;
    mode = m;
    repeat (7) @(negedge clk);
    cs = 1'b0;
    cs_fall = cyc + 1;
    mode_lat = m;
    if (coincide) sclk = ~sclk;
    for (int i = 0; i < edges; i++) begin
      repeat ($urandom_range(3, 6)) @(negedge clk);
      toggle();
      if (flip && i == 2) mode = m ^ 2'b01;
    end
    if (sclk != lvl) begin
      repeat (4) @(negedge clk);
      toggle();
    end
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    compare(tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_cyc;
    ev_t keep[$];

    repeat (2) begin
      @(negedge clk);
      sclk = ~sclk;
      @(posedge clk);
      #1;
      check("rst_shift", shift, 0);
      check("rst_sample", sample, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    sclk = 1'b0;
    @(posedge clk);
    #1;
    check("rel_shift", shift, 0);
    check("rel_sample", sample, 0);
    repeat (10) @(negedge clk);
    compare("idle");

    xfer("m0", 2'b00, 1'b0, 2, 1'b0, 1'b0);
    xfer("m1", 2'b01, 1'b1, 2, 1'b0, 1'b0);
    xfer("m2", 2'b10, 1'b1, 6, 1'b0, 1'b0);
    xfer("m3", 2'b11, 1'b1, 6, 1'b0, 1'b0);
    xfer("flip", 2'b00, 1'b0, 8, 1'b0, 1'b1);
    xfer("coinc", 2'b00, 1'b0, 4, 1'b1, 1'b0);

    // free-running SCLK with CS high must never strobe
    @(negedge clk);
    cs = 1'b1;
    repeat (13) #15 sclk = ~sclk;
    repeat (10) @(negedge clk);
    compare("cs_high");

    // reset while a falling edge is still in the pipeline
    @(negedge clk);
    sclk = 1'b0;
    mode = 2'b00;
    repeat (7) @(negedge clk);
    cs = 1'b0;
    cs_fall = cyc + 1;
    mode_lat = 2'b00;
    repeat (4) @(negedge clk);
    toggle();
    repeat (6) @(negedge clk);
    toggle();
    @(negedge clk);
    reset = 1'b1;
    cs = 1'b1;
    rst_cyc = cyc + 1;
    @(posedge clk);
    #1;
    check("rmid_shift", shift, 0);
    check("rmid_sample", sample, 0);
    @(negedge clk);
    reset = 1'b0;
    keep.delete();
    foreach (exp_q[i]) if (exp_q[i].c < rst_cyc) keep.push_back(exp_q[i]);
    exp_q = keep;
    @(posedge clk);
    #1;
    check("rpost_shift", shift, 0);
    check("rpost_sample", sample, 0);
    repeat (10) @(negedge clk);
    compare("rmid");

    for (int t = 0; t < 10; t++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      xfer("rnd", m, m[1], 2 * $urandom_range(1, 4),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
